// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters with a snapshot-and-stream dump port.
// Define PERF_PERIODIC_DUMP_EN to add a free-running DUMP_INTERVAL dump trigger.
module perf_counter_bank #(
  parameter int NUM_CH        = 8,
  parameter int CNT_W         = 32,
  parameter int INC_W         = 4,
  parameter int SATURATE      = 0,
  parameter int DUMP_INTERVAL = 1024,
  localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*INC_W-1:0]   evt_inc,
  input  logic                      freeze,
  input  logic                      clr,
  input  logic                      dump_req,
  output logic                      dump_busy,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [IDX_W-1:0]          dump_idx,
  output logic [CNT_W-1:0]          dump_data,
  output logic                      dump_last,
  output logic [NUM_CH-1:0]         ovf,
  output logic [0:0]                dbg_state
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] nxt    [NUM_CH];
  logic [CNT_W:0]   sum    [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] ovf_r;
  logic             start;

  // Sum is one bit wider than the counter so the carry doubles as the overflow event.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, cnt[i]} + {{(CNT_W + 1 - INC_W){1'b0}}, evt_inc[i*INC_W +: INC_W]};
      carry[i] = sum[i][CNT_W];
      nxt[i]   = (SATURATE != 0 && carry[i]) ? {CNT_W{1'b1}} : sum[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf_r <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf_r <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= nxt[i];
        if (carry[i]) ovf_r[i] <= 1'b1;
      end
    end
  end

`ifdef PERF_PERIODIC_DUMP_EN
  logic [31:0] ivl;
  logic        ivl_tick;

  // A tick that lands while SEND is simply not acted on; the interval restarts regardless.
  assign ivl_tick = (ivl == 32'(DUMP_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ivl <= '0;
    else      ivl <= ivl_tick ? '0 : ivl + 32'd1;
  end

  assign start = dump_req || ivl_tick;
`else
  logic unused_interval;
  assign unused_interval = |32'(DUMP_INTERVAL);
  assign start = dump_req;
`endif

  // Handshake: a beat transfers on any rising edge where dump_valid && dump_ready;
  // dump_idx/dump_data/dump_last stay stable while dump_valid is high and ready is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dump_busy  = (state == SEND);
  assign dump_valid = (state == SEND);
  assign dump_last  = (state == SEND) && (idx == LAST_IDX);
  assign dump_idx   = idx;
  assign dump_data  = shadow[idx];
  assign ovf        = ovf_r;
  assign dbg_state  = state;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: 4 channels x 8 bits, wrap and saturate instances side by side.
module tb_perf_counter_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int IW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NCH*IW-1:0] evt_inc = '0;
  logic freeze = 1'b0, clr = 1'b0, dump_req = 1'b0, dump_ready = 1'b0;

  logic          w_busy, w_valid, w_last, s_busy, s_valid, s_last;
  logic [1:0]    w_idx, s_idx;
  logic [CW-1:0] w_data, s_data;
  logic [NCH-1:0] w_ovf, s_ovf;
  logic [0:0]    w_dbg, s_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_sat_q[$];

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .SATURATE(0), .DUMP_INTERVAL(16)) dut (
    .clk(clk), .rst(rst), .evt_inc(evt_inc), .freeze(freeze), .clr(clr), .dump_req(dump_req),
    .dump_busy(w_busy), .dump_valid(w_valid), .dump_ready(dump_ready), .dump_idx(w_idx),
    .dump_data(w_data), .dump_last(w_last), .ovf(w_ovf), .dbg_state(w_dbg));

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .SATURATE(1), .DUMP_INTERVAL(16)) dut_sat (
    .clk(clk), .rst(rst), .evt_inc(evt_inc), .freeze(freeze), .clr(clr), .dump_req(dump_req),
    .dump_busy(s_busy), .dump_valid(s_valid), .dump_ready(dump_ready), .dump_idx(s_idx),
    .dump_data(s_data), .dump_last(s_last), .ovf(s_ovf), .dbg_state(s_dbg));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [NCH*IW-1:0] inc;
    int                n;
    logic [CW-1:0]     w[NCH];
    logic [CW-1:0]     s[NCH];
    logic [NCH-1:0]    ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // driver tasks: entered at a falling edge, inputs take effect on the next rising edge
  task automatic do_clr();
    clr = 1'b1;
    evt_inc = '0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic apply(input logic [NCH*IW-1:0] inc, input int n);
    evt_inc = inc;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [CW-1:0] w0, w1, w2, w3, s0, s1, s2, s3);
    exp_q.delete();
    exp_sat_q.delete();
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
    exp_sat_q.push_back(s0); exp_sat_q.push_back(s1); exp_sat_q.push_back(s2); exp_sat_q.push_back(s3);
  endtask

  // scoreboard: consume one expected beat per handshake
  task automatic run_dump(input bit toggle);
    int beat;
    int k;
    beat = 0;
    k = 0;
    dump_req = 1'b1;
    dump_ready = toggle ? 1'b0 : 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    chk("busy_on_start", w_busy, 1);
    chk("dbg_state_send", w_dbg, 1);
    while (beat < NCH && k < 200) begin
      dump_ready = toggle ? (((k / 2) % 2) == 1) : 1'b1;
      if (toggle) dump_req = (k == 1);
      chk("valid", w_valid, 1);
      chk("idx", w_idx, beat);
      chk("last", w_last, beat == NCH - 1);
      chk("data_wrap", w_data, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
      chk("data_sat", s_data, (exp_sat_q.size() > 0) ? exp_sat_q[0] : 8'hxx);
      if (w_valid && dump_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_sat_q.size() > 0) void'(exp_sat_q.pop_front());
        beat++;
      end
      @(negedge clk);
      k++;
    end
    dump_req = 1'b0;
    chk("dump_beats", beat, NCH);
    chk("busy_after", w_busy, 0);
    chk("valid_after", w_valid, 0);
    dump_ready = 1'b0;
  endtask

  initial begin
    int c0, n, busy_seen;
    vecs[0] = '{16'h0003, 10, '{8'd30, 8'd0,   8'd0,  8'd0},   '{8'd30, 8'd0,   8'd0,   8'd0},   4'b0000};
    vecs[1] = '{16'h8F21, 5,  '{8'd5,  8'd10,  8'd75, 8'd40},  '{8'd5,  8'd10,  8'd75,  8'd40},  4'b0000};
    vecs[2] = '{16'hF001, 17, '{8'd17, 8'd0,   8'd0,  8'd255}, '{8'd17, 8'd0,   8'd0,   8'd255}, 4'b0000};
    vecs[3] = '{16'h0F90, 18, '{8'd0,  8'd162, 8'd14, 8'd0},   '{8'd0,  8'd162, 8'd255, 8'd0},   4'b0100};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", w_busy, 0);
    chk("rst_valid", w_valid, 0);
    chk("rst_last", w_last, 0);
    chk("rst_idx", w_idx, 0);
    chk("rst_data", w_data, 0);
    chk("rst_ovf", w_ovf, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", w_busy, 0);

    // table-driven vectors
    for (int v = 0; v < 4; v++) begin
      do_clr();
      apply(vecs[v].inc, vecs[v].n);
      chk("vec_ovf_wrap", w_ovf, vecs[v].ovf);
      chk("vec_ovf_sat", s_ovf, vecs[v].ovf);
      evt_inc = '0;
      push_exp(vecs[v].w[0], vecs[v].w[1], vecs[v].w[2], vecs[v].w[3],
               vecs[v].s[0], vecs[v].s[1], vecs[v].s[2], vecs[v].s[3]);
      run_dump(1'b0);
    end

    // 254 + 5: wrap to 3 vs saturate at 255, both flag overflow
    do_clr();
    apply(16'h0002, 127);
    chk("pre_ovf_wrap", w_ovf, 0);
    apply(16'h0005, 1);
    chk("ovf254_wrap", w_ovf, 4'b0001);
    chk("ovf254_sat", s_ovf, 4'b0001);
    evt_inc = '0;
    push_exp(8'd3, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0);
    run_dump(1'b0);

    // reset in the middle of a dump
    dump_req = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idx_before", w_idx, 2);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", w_busy, 0);
    chk("abort_valid", w_valid, 0);
    chk("abort_last", w_last, 0);
    chk("abort_idx", w_idx, 0);
    chk("abort_data", w_data, 0);
    chk("abort_ovf_wrap", w_ovf, 0);
    chk("abort_ovf_sat", s_ovf, 0);
    chk("abort_data_sat", s_data, 0);
    @(negedge clk);
    rst = 1'b1;
    dump_ready = 1'b0;
    apply(16'h0001, 3);
    evt_inc = '0;
    push_exp(8'd3, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0);
    run_dump(1'b0);

    // freeze holds, clr beats freeze and increment
    do_clr();
    apply(16'h00F3, 18);
    chk("frz_ovf_wrap", w_ovf, 4'b0010);
    freeze = 1'b1;
    apply(16'h00F3, 5);
    chk("frz_ovf_hold", s_ovf, 4'b0010);
    evt_inc = '0;
    push_exp(8'd54, 8'd14, 8'd0, 8'd0, 8'd54, 8'd255, 8'd0, 8'd0);
    run_dump(1'b0);
    clr = 1'b1;
    evt_inc = 16'h0077;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ovf_wrap", w_ovf, 0);
    chk("clr_ovf_sat", s_ovf, 0);
    apply(16'h0077, 3);
    evt_inc = '0;
    push_exp(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_dump(1'b0);
    freeze = 1'b0;

    // stalled dump while counting continues; a request during SEND is ignored
    do_clr();
    evt_inc = 16'h0013;
    c0 = cyc;
    repeat (10) @(negedge clk);
    push_exp(8'd30, 8'd10, 8'd0, 8'd0, 8'd30, 8'd10, 8'd0, 8'd0);
    run_dump(1'b1);
    evt_inc = '0;
    n = cyc - c0;
    push_exp(8'(3 * n), 8'(n), 8'd0, 8'd0, 8'(3 * n), 8'(n), 8'd0, 8'd0);
    run_dump(1'b0);

    // no spontaneous dumps unless the periodic trigger is built in
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_busy) busy_seen++;
    end
`ifdef PERF_PERIODIC_DUMP_EN
    chk("periodic_dump_seen", busy_seen > 0, 1);
`else
    chk("no_spontaneous_dump", busy_seen, 0);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of event channels (2..64).
REQ-002 SHALL have parameter CNT_W, default 32, counter width per channel (8..64).
REQ-003 SHALL have parameter INC_W, default 4, per-channel per-cycle increment width (1..8).
REQ-004 SHALL have parameter SATURATE, default 0, where 0 means wrap and 1 means saturate at all-ones.
REQ-005 SHALL have parameter DUMP_INTERVAL, default 1024, cycles between automatic dumps (used only under REQ-029).
REQ-006 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: evt_inc  in  NUM_CH*INC_W  unsigned increment, channel i at bits [i*INC_W +: INC_W].
REQ-009 SHALL have ports: freeze  in  1  hold all counters.
REQ-010 SHALL have ports: clr  in  1  synchronous clear of counters and overflow flags.
REQ-011 SHALL have ports: dump_req  in  1  start a dump.
REQ-012 SHALL have ports: dump_busy  out  1  dump in progress.
REQ-013 SHALL have ports: dump_valid  out  1, dump_ready  in  1  output stream handshake.
REQ-014 SHALL have ports: dump_idx  out  max(1,$clog2(NUM_CH))  channel index of dump_data.
REQ-015 SHALL have ports: dump_data  out  CNT_W  snapshot value; dump_last  out  1  final beat.
REQ-016 SHALL have ports: ovf  out  NUM_CH  sticky per-channel overflow flag.

Function
REQ-017 Each cycle with freeze=0 and clr=0, counter i SHALL become counter i + evt_inc[i], zero-extended to CNT_W.
REQ-018 SATURATE=0: sum SHALL wrap modulo 2^CNT_W; SATURATE=1: counter SHALL hold at all-ones once reached.
REQ-019 Carry out of CNT_W in REQ-017 SHALL set ovf[i], held until clr or reset.
REQ-020 clr SHALL take priority over freeze and increment; the counter and ovf are zero the next cycle.
REQ-021 Dump FSM SHALL have states IDLE and SEND; dump_busy=1 exactly in SEND.
REQ-022 In IDLE, dump_req=1 SHALL copy all pre-update counter values into a shadow array, set index to 0, and enter SEND next cycle.
REQ-023 In SEND, dump_valid SHALL be 1 with dump_idx=index and dump_data=shadow[index], stable until dump_valid&&dump_ready.
REQ-024 Each handshake SHALL increment index; dump_last=1 when index=NUM_CH-1; the handshake on the last beat SHALL return to IDLE.
REQ-025 dump_req in SEND SHALL be ignored, not queued; counters keep counting during SEND; clr SHALL NOT alter the shadow.
REQ-026 Stalls (dump_ready=0) of any length SHALL NOT drop or repeat beats.

Reset
REQ-027 rst=0 SHALL asynchronously force all counters, shadow, ovf and index to 0 and the FSM to IDLE.
REQ-028 Outputs under reset SHALL be dump_busy=0, dump_valid=0, dump_last=0, dump_idx=0, dump_data=0, ovf=0; reset in SEND aborts the dump without a final beat.

Configuration
REQ-029 With PERF_PERIODIC_DUMP_EN defined, a free-running interval counter SHALL generate an internal dump request every DUMP_INTERVAL cycles, ORed with dump_req; if the FSM is in SEND the request SHALL be dropped and the interval restarted.
REQ-030 Without PERF_PERIODIC_DUMP_EN, the interval counter SHALL be absent and only dump_req starts a dump.

Verification
REQ-031 NUM_CH=4, CNT_W=8, channel 0 evt_inc=3 for 10 cycles, then dump_req, dump_ready=1 -> 4 consecutive beats, idx 0..3, beat 0 data=30, dump_last on idx 3.
REQ-032 SATURATE=0, CNT_W=8, counter=254, inc=5 -> counter=3, ovf[i]=1; SATURATE=1 same stimulus -> counter=255, ovf[i]=1.
REQ-033 Dump with dump_ready toggled 0/1 every 2 cycles, increments continuing -> data equals snapshot at request, no drop/repeat, counters still advance.
REQ-034 clr and evt_inc=7 in the same cycle, plus freeze=1 -> counter=0, ovf=0 next cycle; freeze alone holds values.
REQ-035 rst asserted mid-SEND at beat 2 -> outputs zero immediately, no dump_last, next dump_req restarts at idx 0.
REQ-036 PERF_PERIODIC_DUMP_EN, DUMP_INTERVAL=16, dump_ready=1 -> dump starts every 16 cycles; with the macro undefined -> no dump without dump_req.
